uart_tx_fifo: RTL

- Next-generation UART transmitter: TX FIFO with valid/ready write side, runtime baud divisor, 5-8 data bits, parity none/even/odd/mark, 1 or 2 stop bits.
- Sits between the bus/CPU-side register block and the UART pin.
- Frame configuration is sampled per frame, so software may reprogram between characters without corrupting a frame in flight.

---
 rtl/uart_tx_fifo_if.sv | 11 +
 rtl/uart_tx_fifo.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake bundle for uart_tx_fifo: valid/ready character push.
interface uart_tx_fifo_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  // Producer side (register block / CPU)
  modport master (output in_valid, output in_data, input in_ready);
  // Consumer side (the transmitter's FIFO)
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with TX FIFO, runtime divisor, 5-8 data bits, parity
// none/even/odd/mark and 1 or 2 stop bits. Frame settings are captured when
// a frame starts, so they may be reprogrammed between characters.
// Optional: define UART_TX_CTS_EN to add the uart_cts_n flow-control input.
module uart_tx_fifo #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned RESET_DIV  = 434
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [DIV_W-1:0]             cfg_div,
  input  logic [1:0]                   cfg_data_bits,
  input  logic [1:0]                   cfg_parity,
  input  logic                         cfg_stop2,
`ifdef UART_TX_CTS_EN
  input  logic                         uart_cts_n,
`endif
  uart_tx_fifo_if.slave                wr,
  output logic                         uart_txd,
  output logic                         uart_tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         tx_done
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             in_ready_q;

  state_t           state;
  logic [DIV_W-1:0] cyc;
  logic [DIV_W-1:0] div_l;
  logic [1:0]       bits_l;
  logic [1:0]       par_l;
  logic             stop2_l;
  logic             par_bit;
  logic [7:0]       sr;
  logic [2:0]       bit_idx;
  logic             stop_idx;

  logic             cts_ok;
  logic             push;
  logic             pop;
  logic             can_start;
  logic             bit_end;
  logic             frame_end;
  logic             going_idle;
  logic [CW-1:0]    count_nxt;
  logic [7:0]       head;
  logic [7:0]       head_masked;
  logic             head_par;
  logic [DIV_W-1:0] div_eff;
  logic [2:0]       last_bit;

`ifdef UART_TX_CTS_EN
  logic cts_s1;
  logic cts_s2;

  // Two-flop synchroniser for the asynchronous clear-to-send input
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cts_s1 <= 1'b1;
      cts_s2 <= 1'b1;
    end else begin
      cts_s1 <= uart_cts_n;
      cts_s2 <= cts_s1;
    end
  end

  assign cts_ok = !cts_s2;
`else
  assign cts_ok = 1'b1;
`endif

  assign wr.in_ready  = in_ready_q;
  assign push         = wr.in_valid && in_ready_q;
  assign can_start    = (fifo_count != '0) && cts_ok;
  assign bit_end      = (cyc == div_l - DIV_W'(1));
  assign frame_end    = (state == S_STOP) && bit_end && (stop_idx == stop2_l);
  assign pop          = can_start && ((state == S_IDLE) || frame_end);
  assign going_idle   = ((state == S_IDLE) || frame_end) && !can_start;
  assign count_nxt    = fifo_count + CW'(push) - CW'(pop);
  assign head         = mem[rd_ptr];
  assign head_masked  = head & (8'hFF >> (2'd3 - cfg_data_bits));
  assign head_par     = (cfg_parity == 2'b11) ? 1'b1 : ((^head_masked) ^ (cfg_parity == 2'b10));
  assign div_eff      = (cfg_div < DIV_W'(4)) ? DIV_W'(RESET_DIV) : cfg_div;
  assign last_bit     = 3'd4 + 3'(bits_l);

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr.in_data;
  end

  // FIFO pointers, occupancy, status outputs and the transmit FSM
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      in_ready_q   <= 1'b1;
      uart_tx_busy <= 1'b0;
      tx_done      <= 1'b0;
      uart_txd     <= 1'b1;
      state        <= S_IDLE;
      cyc          <= '0;
      div_l        <= DIV_W'(RESET_DIV);
      bits_l       <= '0;
      par_l        <= '0;
      stop2_l      <= 1'b0;
      par_bit      <= 1'b0;
      sr           <= '0;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
    end else begin
      tx_done      <= 1'b0;
      fifo_count   <= count_nxt;
      in_ready_q   <= (count_nxt != CW'(FIFO_DEPTH));
      uart_tx_busy <= !going_idle || (count_nxt != '0);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (state != S_IDLE) cyc <= bit_end ? '0 : cyc + DIV_W'(1);

      // A launch pops the head and freezes this frame's settings
      if (pop) begin
        state    <= S_START;
        uart_txd <= 1'b0;
        sr       <= head;
        par_bit  <= head_par;
        div_l    <= div_eff;
        bits_l   <= cfg_data_bits;
        par_l    <= cfg_parity;
        stop2_l  <= cfg_stop2;
      end else begin
        case (state)
          S_IDLE: ;
          S_START: if (bit_end) begin
            state    <= S_DATA;
            uart_txd <= sr[0];
            sr       <= sr >> 1;
            bit_idx  <= '0;
          end
          S_DATA: if (bit_end) begin
            if (bit_idx == last_bit) begin
              if (par_l != 2'b00) begin
                state    <= S_PARITY;
                uart_txd <= par_bit;
              end else begin
                state    <= S_STOP;
                uart_txd <= 1'b1;
                stop_idx <= 1'b0;
              end
            end else begin
              uart_txd <= sr[0];
              sr       <= sr >> 1;
              bit_idx  <= bit_idx + 3'd1;
            end
          end
          S_PARITY: if (bit_end) begin
            state    <= S_STOP;
            uart_txd <= 1'b1;
            stop_idx <= 1'b0;
          end
          S_STOP: if (bit_end) begin
            if (stop_idx == stop2_l) begin
              state    <= S_IDLE;
              uart_txd <= 1'b1;
            end else begin
              stop_idx <= 1'b1;
            end
          end
          default: begin
            state    <= S_IDLE;
            uart_txd <= 1'b1;
          end
        endcase
      end

      // End of the last stop bit, whether or not another frame follows
      if (frame_end) tx_done <= 1'b1;
    end
  end

endmodule
